// File: rtl/xor_apuf_engine_pkg.sv
// Shared types and width helpers for the XOR arbiter-PUF evaluation engine.
package xor_apuf_engine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_SAMPLE,
    ST_DISCHARGE,
    ST_DONE
  } state_t;

  // Bits needed to hold a count from 0 to n inclusive (VOTE_W, SETTLE_W).
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/xor_apuf_engine_apuf_chain.sv
// One arbiter PUF chain: a ladder of crossing/straight switch stages feeding a D-flop arbiter.
module apuf_chain #(
  parameter int STAGES = 64
) (
  input  logic              x,
  input  logic              y,
  input  logic [STAGES-1:0] chal,
  output logic              arb
);

  // Each stage gets its own nets so the two race paths stay physically distinct.
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic t_in;
    logic b_in;
    (* dont_touch = "true" *) logic t_out;
    (* dont_touch = "true" *) logic b_out;

    if (i == 0) begin : g_head
      assign t_in = x;
      assign b_in = y;
    end else begin : g_link
      assign t_in = g_stage[i-1].t_out;
      assign b_in = g_stage[i-1].b_out;
    end

    assign t_out = chal[i] ? b_in : t_in;
    assign b_out = chal[i] ? t_in : b_in;
  end

  logic top_end;
  logic bot_end;
  assign top_end = g_stage[STAGES-1].t_out;
  assign bot_end = g_stage[STAGES-1].b_out;

  // Arbiter: 1 when the top path wins the race to the flop.
  always_ff @(posedge bot_end) begin
    arb <= top_end;
  end

endmodule

// File: rtl/xor_apuf_engine.sv
// XOR arbiter PUF engine: takes a challenge, races every chain VOTES times,
// majority-votes each chain and returns the XOR of the votes plus a stability flag.
module xor_apuf_engine
  import xor_apuf_engine_pkg::*;
#(
  parameter int N_CHAINS   = 4,
  parameter int STAGES     = 64,
  parameter int VOTES      = 5,
  parameter int SETTLE_CYC = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         chal_valid,
  output logic                         chal_ready,
  input  logic [N_CHAINS*STAGES-1:0]   chal_data,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic                         resp_bit,
  output logic [N_CHAINS-1:0]          resp_raw,
  output logic                         resp_stable
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1;
  // a producer holds valid and its data stable until that edge.

  localparam int VOTE_W   = cnt_width(VOTES);
  localparam int SETTLE_W = cnt_width(SETTLE_CYC);
  localparam int CW       = N_CHAINS * STAGES;
  localparam logic [SETTLE_W-1:0] PHASE_LAST = SETTLE_W'(SETTLE_CYC - 1);
  localparam logic [VOTE_W-1:0]   VOTE_LAST  = VOTE_W'(VOTES - 1);
  localparam logic [VOTE_W-1:0]   VOTE_HALF  = VOTE_W'(VOTES / 2);

  state_t              state;
  state_t              state_nxt;
  logic [SETTLE_W-1:0] phase;
  logic                phase_end;
  logic [VOTE_W-1:0]   vote_idx;
  logic [CW-1:0]       chal_reg;
  logic                race_in;
  logic                accept;
  logic [N_CHAINS-1:0] arb;
  logic [N_CHAINS-1:0] arb_meta;
  logic [N_CHAINS-1:0] arb_sync;
  logic [N_CHAINS-1:0] first_vote;
  logic [N_CHAINS-1:0] mismatch;
  logic [N_CHAINS-1:0] raw_nxt;
  logic [VOTE_W-1:0]   cnt [N_CHAINS];

  assign phase_end  = (phase == PHASE_LAST);
  assign chal_ready = (state == ST_IDLE);
  assign accept     = chal_valid & chal_ready;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:      if (chal_valid) state_nxt = ST_LAUNCH;
      ST_LAUNCH:    if (phase_end) state_nxt = ST_SAMPLE;
      ST_SAMPLE:    state_nxt = ST_DISCHARGE;
      ST_DISCHARGE: if (phase_end) state_nxt = (vote_idx == VOTE_LAST) ? ST_DONE : ST_LAUNCH;
      ST_DONE:      if (resp_valid && resp_ready) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // race_in is a flop so the fabric never sees decode glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      race_in <= 1'b0;
      phase   <= '0;
    end else begin
      race_in <= (state_nxt == ST_LAUNCH) || (state_nxt == ST_SAMPLE);
      if (state == ST_LAUNCH || state == ST_DISCHARGE) begin
        phase <= phase_end ? '0 : phase + 1'b1;
      end else begin
        phase <= '0;
      end
    end
  end

  // Arbiter outputs are asynchronous to clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arb_meta <= '0;
      arb_sync <= '0;
    end else begin
      arb_meta <= arb;
      arb_sync <= arb_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chal_reg   <= '0;
      vote_idx   <= '0;
      first_vote <= '0;
      mismatch   <= '0;
      for (int c = 0; c < N_CHAINS; c++) cnt[c] <= '0;
    end else if (accept) begin
      chal_reg   <= chal_data;
      vote_idx   <= '0;
      first_vote <= '0;
      mismatch   <= '0;
      for (int c = 0; c < N_CHAINS; c++) cnt[c] <= '0;
    end else if (state == ST_SAMPLE) begin
      for (int c = 0; c < N_CHAINS; c++) cnt[c] <= cnt[c] + VOTE_W'(arb_sync[c]);
      if (vote_idx == '0) begin
        first_vote <= arb_sync;
      end else begin
        mismatch <= mismatch | (arb_sync ^ first_vote);
      end
    end else if (state == ST_DISCHARGE && phase_end) begin
      vote_idx <= vote_idx + 1'b1;
    end
  end

  always_comb begin
    raw_nxt = '0;
    for (int c = 0; c < N_CHAINS; c++) raw_nxt[c] = (cnt[c] > VOTE_HALF);
  end

  // Results are captured once on the first DONE cycle, then held until consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid  <= 1'b0;
      resp_raw    <= '0;
      resp_bit    <= 1'b0;
      resp_stable <= 1'b0;
    end else if (state == ST_DONE) begin
      if (!resp_valid) begin
        resp_valid  <= 1'b1;
        resp_raw    <= raw_nxt;
        resp_bit    <= ^raw_nxt;
        resp_stable <= ~|mismatch;
      end else if (resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

  for (genvar c = 0; c < N_CHAINS; c++) begin : g_chain
    (* dont_touch = "true" *)
    apuf_chain #(
      .STAGES(STAGES)
    ) u_chain (
      .x    (race_in),
      .y    (race_in),
      .chal (chal_reg[c*STAGES +: STAGES]),
      .arb  (arb[c])
    );
  end

endmodule
